csr_trap_unit: RTL

- Parametrised machine-mode CSR file and trap controller for the RV32IMC single-cycle core.
- Executes Zicsr read/modify/write operations and holds 64-bit cycle and instret counters.
- Arbitrates standard and NUM_LOCAL_INT platform interrupts against synchronous exceptions.
- Drives trap entry (direct or vectored) and mret return targets to the PC logic.

---
 rtl/csr_trap_unit_if.sv | 36 +++
 rtl/csr_trap_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_if.sv
// csr_trap_unit_if: Zicsr access bus between the core's decode/execute stage
// and the CSR file.
//
// Signals:
//   csr_valid_in   current instruction is a CSR op (funct3 != 0)
//   funct3_in      CSRRW/S/C = 001/010/011, CSRRWI/SI/CI = 101/110/111
//   csr_addr_in    12-bit CSR address
//   rs1_in         register operand
//   zimm_in        immediate operand for the I forms
//   rs1_is_x0_in   rs1/zimm field is zero (S/C forms then do not write)
//   csr_rdata_out  old CSR value for rd, combinational
//
// Handshake: there is no valid/ready pair. The op is accepted in every cycle
// csr_valid_in is high, the read data is valid in that same cycle, and the
// write (if any) commits at the next rising edge. The slave never stalls.
interface csr_trap_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_valid_in;
  logic [2:0]      funct3_in;
  logic [11:0]     csr_addr_in;
  logic [XLEN-1:0] rs1_in;
  logic [4:0]      zimm_in;
  logic            rs1_is_x0_in;
  logic [XLEN-1:0] csr_rdata_out;

  modport master (
    output csr_valid_in, funct3_in, csr_addr_in, rs1_in, zimm_in, rs1_is_x0_in,
    input  csr_rdata_out
  );

  modport slave (
    input  csr_valid_in, funct3_in, csr_addr_in, rs1_in, zimm_in, rs1_is_x0_in,
    output csr_rdata_out
  );
endinterface

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller for an RV32IMC
// single-cycle core.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-low reset
//   csr_bus (slave)     Zicsr access bus, see csr_trap_unit_if
//   illegal_instr_in, ecall_in, ebreak_in, misaligned_in, fault_addr_in
//                       synchronous exceptions of the current instruction
//   mret_in             mret executing
//   ext_int_in, sw_int_in, timer_int_in, local_int_in
//                       level interrupt lines, sampled into mip
//   pc_in, instret_in   current PC, instruction retires this cycle
//   trap_taken_out, trap_address_out   trap entry and its target (comb.)
//   mret_taken_out, mepc_out           mret accepted, return target
//
// All CSR side effects commit at the rising edge. A trap in the current cycle
// wins over everything: the CSR write, mret and the minstret increment are
// dropped for that instruction.
module csr_trap_unit #(
  parameter int          XLEN          = 32,
  parameter int          NUM_LOCAL_INT = 4,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL      = 32'h4000_1104,
  parameter logic [31:0] HART_ID       = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  csr_trap_unit_if.slave           csr_bus,
  input  logic                     illegal_instr_in,
  input  logic                     ecall_in,
  input  logic                     ebreak_in,
  input  logic                     misaligned_in,
  input  logic [XLEN-1:0]          fault_addr_in,
  input  logic                     mret_in,
  input  logic                     ext_int_in,
  input  logic                     sw_int_in,
  input  logic                     timer_int_in,
  input  logic [NUM_LOCAL_INT-1:0] local_int_in,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     instret_in,
  output logic                     trap_taken_out,
  output logic [XLEN-1:0]          trap_address_out,
  output logic                     mret_taken_out,
  output logic [XLEN-1:0]          mepc_out
);

  localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MISA          = 12'h301;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;

  // Only the interrupt enables that have a source behind them are kept.
  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | (((32'h1 << NUM_LOCAL_INT) - 32'h1) << 16);

  // Architectural state
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;
  logic        cy_inhibit, ir_inhibit;

  // Combinational decode
  logic [31:0] csr_old, csr_operand, csr_new, mip_next;
  logic        csr_impl, csr_wr_attempt, csr_illegal, csr_we;
  logic        int_valid, exc_valid;
  logic [4:0]  int_code, exc_code;
  logic [31:0] trap_cause, trap_tval, trap_base;
  logic        cy_load_lo, cy_load_hi, ir_load_lo, ir_load_hi;

  // CSR read mux; also flags whether the address exists at all.
  always_comb begin
    csr_impl = 1'b1;
    csr_old  = 32'h0;
    case (csr_bus.csr_addr_in)
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: csr_old = 32'h0;
      ADDR_MHARTID:       csr_old = HART_ID;
      ADDR_MISA:          csr_old = MISA_VAL;
      ADDR_MSTATUS:       csr_old = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:           csr_old = mie_q;
      ADDR_MIP:           csr_old = mip_q;
      ADDR_MTVEC:         csr_old = mtvec_q;
      ADDR_MSCRATCH:      csr_old = mscratch_q;
      ADDR_MEPC:          csr_old = mepc_q;
      ADDR_MCAUSE:        csr_old = mcause_q;
      ADDR_MTVAL:         csr_old = mtval_q;
      ADDR_MCYCLE:        csr_old = mcycle_q[31:0];
      ADDR_MCYCLEH:       csr_old = mcycle_q[63:32];
      ADDR_MINSTRET:      csr_old = minstret_q[31:0];
      ADDR_MINSTRETH:     csr_old = minstret_q[63:32];
      ADDR_MCOUNTINHIBIT: csr_old = {29'b0, ir_inhibit, 1'b0, cy_inhibit};
      default:            csr_impl = 1'b0;
    endcase
  end

  // Read-modify-write value
  always_comb begin
    csr_operand = csr_bus.funct3_in[2] ? {27'b0, csr_bus.zimm_in} : csr_bus.rs1_in;
    case (csr_bus.funct3_in[1:0])
      2'b01:   csr_new = csr_operand;
      2'b10:   csr_new = csr_old | csr_operand;
      2'b11:   csr_new = csr_old & ~csr_operand;
      default: csr_new = csr_old;
    endcase
  end

  // W forms always write; S/C forms only with a non-zero source field.
  assign csr_wr_attempt = csr_bus.csr_valid_in &&
                          ((csr_bus.funct3_in[1:0] == 2'b01) ||
                           ((csr_bus.funct3_in[1:0] != 2'b00) && !csr_bus.rs1_is_x0_in));
  assign csr_illegal    = csr_bus.csr_valid_in &&
                          (!csr_impl || (csr_wr_attempt && (csr_bus.csr_addr_in[11:10] == 2'b11)));

  // Interrupt select. Assignments go from lowest to highest priority so the
  // last matching one wins; the local loop runs downward so index 0 wins.
  always_comb begin
    int_valid = 1'b0;
    int_code  = 5'd0;
    for (int i = NUM_LOCAL_INT - 1; i >= 0; i--) begin
      if (mie_q[16+i] && mip_q[16+i]) begin
        int_valid = 1'b1;
        int_code  = 5'(16 + i);
      end
    end
    if (mie_q[7] && mip_q[7]) begin
      int_valid = 1'b1;
      int_code  = 5'd7;
    end
    if (mie_q[3] && mip_q[3]) begin
      int_valid = 1'b1;
      int_code  = 5'd3;
    end
    if (mie_q[11] && mip_q[11]) begin
      int_valid = 1'b1;
      int_code  = 5'd11;
    end
    int_valid = int_valid && mstatus_mie;
  end

  // Synchronous exception select
  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 5'd0;
    if (misaligned_in)                        exc_code = 5'd0;
    else if (illegal_instr_in || csr_illegal) exc_code = 5'd2;
    else if (ebreak_in)                       exc_code = 5'd3;
    else if (ecall_in)                        exc_code = 5'd11;
    else                                      exc_valid = 1'b0;
  end

  always_comb begin
    trap_cause = int_valid ? {1'b1, 26'b0, int_code} : {1'b0, 26'b0, exc_code};
    trap_tval  = 32'h0;
    if (!int_valid) begin
      if (misaligned_in)                             trap_tval = fault_addr_in;
      else if (ebreak_in && !illegal_instr_in && !csr_illegal) trap_tval = pc_in;
    end
  end

  assign trap_base        = {mtvec_q[31:2], 2'b00};
  assign trap_taken_out   = int_valid || exc_valid;
  assign trap_address_out = (mtvec_q[0] && int_valid) ? trap_base + {25'b0, int_code, 2'b00}
                                                      : trap_base;
  assign mret_taken_out   = mret_in && !trap_taken_out;
  assign mepc_out         = mepc_q;
  assign csr_bus.csr_rdata_out = csr_bus.csr_valid_in ? csr_old : 32'h0;

  assign csr_we     = csr_wr_attempt && !csr_illegal && !trap_taken_out;
  assign cy_load_lo = csr_we && (csr_bus.csr_addr_in == ADDR_MCYCLE);
  assign cy_load_hi = csr_we && (csr_bus.csr_addr_in == ADDR_MCYCLEH);
  assign ir_load_lo = csr_we && (csr_bus.csr_addr_in == ADDR_MINSTRET);
  assign ir_load_hi = csr_we && (csr_bus.csr_addr_in == ADDR_MINSTRETH);

  always_comb begin
    mip_next                      = 32'h0;
    mip_next[3]                   = sw_int_in;
    mip_next[7]                   = timer_int_in;
    mip_next[11]                  = ext_int_in;
    mip_next[16 +: NUM_LOCAL_INT] = local_int_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= 32'h0;
      mip_q        <= 32'h0;
      mtvec_q      <= RESET_MTVEC;
      mscratch_q   <= 32'h0;
      mepc_q       <= 32'h0;
      mcause_q     <= 32'h0;
      mtval_q      <= 32'h0;
      mcycle_q     <= 64'h0;
      minstret_q   <= 64'h0;
      cy_inhibit   <= 1'b0;
      ir_inhibit   <= 1'b0;
    end else begin
      mip_q <= mip_next;

      // A write to either half replaces that cycle's increment.
      if (cy_load_lo)       mcycle_q[31:0]  <= csr_new;
      else if (cy_load_hi)  mcycle_q[63:32] <= csr_new;
      else if (!cy_inhibit) mcycle_q        <= mcycle_q + 64'd1;

      if (ir_load_lo)       minstret_q[31:0]  <= csr_new;
      else if (ir_load_hi)  minstret_q[63:32] <= csr_new;
      else if (instret_in && !trap_taken_out && !ir_inhibit)
                            minstret_q <= minstret_q + 64'd1;

      if (trap_taken_out) begin
        mepc_q       <= pc_in & 32'hFFFF_FFFE;
        mcause_q     <= trap_cause;
        mtval_q      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (mret_in) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
        if (csr_we) begin
          case (csr_bus.csr_addr_in)
            ADDR_MSTATUS: begin
              mstatus_mie  <= csr_new[3];
              mstatus_mpie <= csr_new[7];
            end
            ADDR_MIE:      mie_q      <= csr_new & MIE_MASK;
            ADDR_MTVEC:    mtvec_q    <= {csr_new[31:2], csr_new[1] ? 2'b00 : csr_new[1:0]};
            ADDR_MSCRATCH: mscratch_q <= csr_new;
            ADDR_MEPC:     mepc_q     <= {csr_new[31:1], 1'b0};
            ADDR_MCAUSE:   mcause_q   <= csr_new;
            ADDR_MTVAL:    mtval_q    <= csr_new;
            ADDR_MCOUNTINHIBIT: begin
              cy_inhibit <= csr_new[0];
              ir_inhibit <= csr_new[2];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
